pixel_writer: RTL and testbench

PIXEL_WRITER -- requirements
Module: pixel_writer

---
 rtl/pixel_writer_pkg.sv | 22 ++
 rtl/pixel_writer_if.sv | 38 +++
 rtl/pixel_fifo.sv | 52 +++++
 rtl/pixel_writer.sv | 115 +++++++++++
 tb/tb_pixel_writer.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/pixel_writer_pkg.sv
// Shared definitions for the window/filter/writer image pipeline.
// Holds pixel/address width defaults, window size and FSM encoding.
package pixel_writer_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int ADDR_WIDTH_DEF = 8;
   localparam int FIFO_DEPTH_DEF = 4;
   localparam int WINDOW_N       = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } wr_state_t;

   function automatic logic [31:0] frame_total(
      input logic [15:0] n,
      input logic [15:0] m
   );
      return 32'(n) * 32'(m);
   endfunction

endpackage

// File: rtl/pixel_writer_if.sv
// Frame-control, pixel-stream and memory-write signals of the writer.
// master = driver side (filter + memory), slave = pixel_writer.
interface pixel_writer_if
   import pixel_writer_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

   logic                  start;
   logic [ADDR_WIDTH-1:0] addrBase;
   logic [15:0]           N;
   logic [15:0]           M;
   logic [DATA_WIDTH-1:0] dataIn;
   logic                  validIn;
   logic                  readyOut;
   logic [ADDR_WIDTH-1:0] addrOut;
   logic [DATA_WIDTH-1:0] dataOut;
   logic                  we;
   logic                  wack;
   logic                  busy;
   logic                  frameF;

   modport master (
      output start, addrBase, N, M,
      output dataIn, validIn, wack,
      input  readyOut, addrOut, dataOut,
      input  we, busy, frameF
   );

   modport slave (
      input  start, addrBase, N, M,
      input  dataIn, validIn, wack,
      output readyOut, addrOut, dataOut,
      output we, busy, frameF
   );

endinterface

// File: rtl/pixel_fifo.sv
// Small synchronous pixel buffer between the filter and memory.
// Head entry is read straight from the storage registers.
module pixel_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic             w_wr;
   logic             w_rd;

   // extra pointer bit separates full from empty
   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                    (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_wr    = i_push & ~o_full;
   assign w_rd    = i_pop & ~o_empty;
   assign o_data  = r_mem[r_rptr[AW-1:0]];

   // pointer and storage update; reset also clears the data
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= i_data;
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_rd) begin
            r_rptr <= r_rptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pixel_writer.sv
// Writes a raster-order filtered frame into image memory.
// Pixels are buffered, then written one per acknowledged cycle.
module pixel_writer
   import pixel_writer_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic         clk,
   input  logic         rst,
   pixel_writer_if.slave bus
);

   wr_state_t             r_state;
   wr_state_t             w_next;
   logic [31:0]           r_total;
   logic [31:0]           r_wr_cnt;
   logic [31:0]           r_acc_cnt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_frame;

   logic                  w_idle;
   logic                  w_run;
   logic                  w_zero;
   logic                  w_start_ok;
   logic                  w_start_zero;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_last;
   logic                  w_full;
   logic                  w_empty;
   logic [DATA_WIDTH-1:0] w_head;

   assign w_idle       = (r_state == ST_IDLE);
   assign w_run        = (r_state == ST_RUN);
   assign w_zero       = (bus.N == 16'd0) | (bus.M == 16'd0);
   assign w_start_ok   = w_idle & bus.start & ~w_zero;
   assign w_start_zero = w_idle & bus.start & w_zero;

   assign bus.readyOut = w_run & ~w_full & (r_acc_cnt < r_total);
   assign bus.we       = w_run & ~w_empty;
   assign bus.addrOut  = r_addr;
   assign bus.dataOut  = w_head;
   assign bus.busy     = w_run;
   assign bus.frameF   = r_frame;

   assign w_push = bus.validIn & bus.readyOut;
   assign w_pop  = bus.we & bus.wack;
   assign w_last = w_pop & (r_wr_cnt == r_total - 32'd1);

   pixel_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (bus.dataIn),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // next state: start only honoured in IDLE, leave on last write
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: if (w_start_ok) w_next = ST_RUN;
         ST_RUN:  if (w_last)     w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // frame counters, write address and completion flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_total   <= '0;
         r_wr_cnt  <= '0;
         r_acc_cnt <= '0;
         r_addr    <= '0;
         r_frame   <= 1'b0;
      end else if (w_start_ok) begin
         r_total   <= frame_total(bus.N, bus.M);
         r_wr_cnt  <= '0;
         r_acc_cnt <= '0;
         r_addr    <= bus.addrBase;
         r_frame   <= 1'b0;
      end else if (w_start_zero) begin
         r_frame   <= 1'b1;
      end else begin
         if (w_push) begin
            r_acc_cnt <= r_acc_cnt + 32'd1;
         end
         if (w_pop) begin
            r_wr_cnt <= r_wr_cnt + 32'd1;
            r_addr   <= r_addr + 1'b1;
         end
         if (w_last) begin
            r_frame <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pixel_writer.sv
// Directed self-checking bench for pixel_writer.
// Expected addresses/data are derived from frame parameters.
module tb_pixel_writer;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   pixel_writer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

   pixel_writer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp_v
   );
      n_cmp++;
      assert (obs === exp_v) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Start a frame, stream pixels 1..n*m, stall wack on one write,
   // optionally pulse start mid-frame, stop after 'limit' writes.
   task automatic run_frame(
      input logic [7:0] base,
      input int         n,
      input int         m,
      input int         limit,
      input int         stall_at,
      input int         stall_len,
      input int         inj_at
   );
      int   npix;
      int   sent;
      int   wrote;
      int   cyc;
      int   st_cnt;
      logic prev_stall;
      logic saw_full;
      logic do_push;
      logic do_pop;
      npix       = n * m;
      sent       = 0;
      wrote      = 0;
      cyc        = 0;
      st_cnt     = 0;
      prev_stall = 1'b0;
      saw_full   = 1'b0;
      bus.start    = 1'b1;
      bus.addrBase = base;
      bus.N        = 16'(n);
      bus.M        = 16'(m);
      bus.validIn  = 1'b0;
      bus.wack     = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("busy_run", 32'(bus.busy), 32'd1);
      chk("frame_clr", 32'(bus.frameF), 32'd0);
      while (wrote < limit && cyc < 200) begin
         bus.start = (cyc == inj_at);
         if (cyc == inj_at) begin
            bus.addrBase = 8'h80;
            bus.N        = 16'd8;
            bus.M        = 16'd8;
         end
         bus.validIn = (sent < npix);
         bus.dataIn  = 8'(sent + 1);
         if (cyc == 0) chk("we_empty", 32'(bus.we), 32'd0);
         if (cyc == 1) chk("latency1", 32'(bus.we), 32'd1);
         if (prev_stall) chk("we_hold", 32'(bus.we), 32'd1);
         if (bus.we) begin
            chk("addr", 32'(bus.addrOut), 32'(8'(base + 8'(wrote))));
            chk("data", 32'(bus.dataOut), 32'(wrote + 1));
         end
         if (!bus.readyOut && sent < npix && sent > 0) saw_full = 1'b1;
         if (bus.we && wrote == stall_at && st_cnt < stall_len) begin
            bus.wack = 1'b0;
            st_cnt++;
         end else begin
            bus.wack = 1'b1;
         end
         do_push    = bus.validIn & bus.readyOut;
         do_pop     = bus.we & bus.wack;
         prev_stall = bus.we & ~bus.wack;
         @(negedge clk);
         if (do_push) sent++;
         if (do_pop) wrote++;
         cyc++;
      end
      bus.start = 1'b0;
      bus.wack  = 1'b1;
      chk("write_cnt", 32'(wrote), 32'(limit));
      if (stall_len > 0) chk("ready_drop", 32'(saw_full), 32'd1);
      if (limit == npix) begin
         chk("accepted", 32'(sent), 32'(npix));
         chk("frame_set", 32'(bus.frameF), 32'd1);
         chk("busy_done", 32'(bus.busy), 32'd0);
         chk("we_done", 32'(bus.we), 32'd0);
         chk("ready_done", 32'(bus.readyOut), 32'd0);
      end
   endtask

   initial begin
      n_cmp        = 0;
      n_bad        = 0;
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.addrBase = '0;
      bus.N        = '0;
      bus.M        = '0;
      bus.dataIn   = '0;
      bus.validIn  = 1'b0;
      bus.wack     = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // reset state
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_we", 32'(bus.we), 32'd0);
      chk("rst_ready", 32'(bus.readyOut), 32'd0);
      chk("rst_frame", 32'(bus.frameF), 32'd0);
      chk("rst_addr", 32'(bus.addrOut), 32'd0);
      chk("rst_data", 32'(bus.dataOut), 32'd0);

      // 3x2 frame, back-to-back, no stalls
      run_frame(8'h10, 3, 2, 6, -1, 0, -1);

      // 4x2 frame, three-cycle wack stall on the second write
      run_frame(8'h30, 4, 2, 8, 1, 3, -1);

      // address wrap at top of memory
      run_frame(8'hFE, 4, 1, 4, -1, 0, -1);

      // reset after two writes, then full frame from base
      run_frame(8'h20, 3, 2, 2, -1, 0, -1);
      bus.validIn = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_we", 32'(bus.we), 32'd0);
      chk("mid_rst_ready", 32'(bus.readyOut), 32'd0);
      chk("mid_rst_frame", 32'(bus.frameF), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_addr", 32'(bus.addrOut), 32'd0);
      run_frame(8'h20, 3, 2, 6, -1, 0, -1);

      // clear frameF, then zero-height start
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("pre_zero_frame", 32'(bus.frameF), 32'd0);
      bus.start = 1'b1;
      bus.N     = 16'd5;
      bus.M     = 16'd0;
      @(negedge clk);
      bus.start = 1'b0;
      chk("zero_frame", 32'(bus.frameF), 32'd1);
      chk("zero_we", 32'(bus.we), 32'd0);
      chk("zero_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      chk("zero_we2", 32'(bus.we), 32'd0);

      // start pulsed mid-frame is ignored
      run_frame(8'h40, 2, 2, 4, -1, 0, 2);
      @(negedge clk);
      chk("ign_busy", 32'(bus.busy), 32'd0);
      chk("ign_we", 32'(bus.we), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
